// File: rtl/rx_pcs_decoder_pkg.sv
// Shared definitions for the 64b/66b receive decoder: XGMII characters,
// block-type field values, 7-bit control codes and state encodings.
package rx_pcs_decoder_pkg;

    // XGMII characters
    localparam logic [7:0] XGMII_IDLE  = 8'h07;
    localparam logic [7:0] XGMII_START = 8'hFB;
    localparam logic [7:0] XGMII_TERM  = 8'hFD;
    localparam logic [7:0] XGMII_ERROR = 8'hFE;
    localparam logic [7:0] XGMII_SEQ   = 8'h9C;

    // Sync headers
    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    // Block-type field values
    localparam logic [7:0] BT_CTRL   = 8'h1E;
    localparam logic [7:0] BT_START0 = 8'h78;
    localparam logic [7:0] BT_START4 = 8'h33;
    localparam logic [7:0] BT_OS0    = 8'h4B;
    localparam logic [7:0] BT_TERM0  = 8'h87;
    localparam logic [7:0] BT_TERM1  = 8'h99;
    localparam logic [7:0] BT_TERM2  = 8'hAA;
    localparam logic [7:0] BT_TERM3  = 8'hB4;
    localparam logic [7:0] BT_TERM4  = 8'hCC;
    localparam logic [7:0] BT_TERM5  = 8'hD2;
    localparam logic [7:0] BT_TERM6  = 8'hE1;
    localparam logic [7:0] BT_TERM7  = 8'hFF;

    // 7-bit control codes carried inside control blocks
    localparam logic [6:0] CODE_IDLE  = 7'h00;
    localparam logic [6:0] CODE_ERROR = 7'h1E;

    // Local-fault ordered set column: 9C,00,00,01 with only lane 0 as control
    localparam logic [31:0] LF_COLUMN = 32'h0100009C;
    localparam logic [3:0]  LF_CTL    = 4'b0001;

    typedef enum logic {
        RX_C = 1'b0,
        RX_D = 1'b1
    } seq_state_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_LOWER = 2'd1,
        BUF_UPPER = 2'd2
    } buf_phase_t;

    // Map a 7-bit control code to its XGMII character; bit 8 flags an illegal code
    function automatic logic [8:0] map_ctrl_code(input logic [6:0] code);
        case (code)
            CODE_IDLE:  return {1'b0, XGMII_IDLE};
            CODE_ERROR: return {1'b0, XGMII_ERROR};
            default:    return {1'b1, XGMII_ERROR};
        endcase
    endfunction

endpackage

// File: rtl/rx_pcs_decoder_block_decode.sv
// Combinational 66-bit block decoder: turns sync header + payload into eight
// XGMII lanes with per-lane control flags and classifies the block for the
// receive sequence FSM. Classification flags are cleared on illegal blocks.
module pcs_block_decode
    import rx_pcs_decoder_pkg::*;
(
    input  logic [1:0]  header,
    input  logic [63:0] block,
    output logic [63:0] data,
    output logic [7:0]  ctl,
    output logic        illegal,
    output logic        is_start,
    output logic        is_term,
    output logic        is_data
);

    // Payload octets shifted down past the type byte; octet i+1 sits in lane i
    logic [63:0] payload;
    logic [8:0]  code_map;
    logic [2:0]  term_lane;

    assign payload = {8'h00, block[63:8]};

    // Decode block type into lanes, ctl and classification
    always_comb begin
        data      = {8{XGMII_IDLE}};
        ctl       = 8'hFF;
        illegal   = 1'b0;
        is_start  = 1'b0;
        is_term   = 1'b0;
        is_data   = 1'b0;
        term_lane = 3'd0;
        code_map  = 9'd0;
        if (header == SH_DATA) begin
            data    = block;
            ctl     = 8'h00;
            is_data = 1'b1;
        end else if (header == SH_CTRL) begin
            case (block[7:0])
                BT_CTRL: begin
                    for (int i = 0; i < 8; i++) begin
                        code_map        = map_ctrl_code(block[8+7*i +: 7]);
                        data[8*i +: 8]  = code_map[7:0];
                        illegal         = illegal | code_map[8];
                    end
                end
                BT_START0: begin
                    data     = {block[63:8], XGMII_START};
                    ctl      = 8'h01;
                    is_start = 1'b1;
                end
                BT_START4: begin
                    for (int i = 0; i < 4; i++) begin
                        code_map        = map_ctrl_code(block[8+7*i +: 7]);
                        data[8*i +: 8]  = code_map[7:0];
                        illegal         = illegal | code_map[8];
                    end
                    data[39:32] = XGMII_START;
                    data[63:40] = block[63:40];
                    ctl         = 8'h1F;
                    is_start    = 1'b1;
                end
                BT_OS0: begin
                    data = {{4{XGMII_IDLE}}, block[31:8], XGMII_SEQ};
                    ctl  = 8'hF1;
                end
                BT_TERM0: begin is_term = 1'b1; term_lane = 3'd0; end
                BT_TERM1: begin is_term = 1'b1; term_lane = 3'd1; end
                BT_TERM2: begin is_term = 1'b1; term_lane = 3'd2; end
                BT_TERM3: begin is_term = 1'b1; term_lane = 3'd3; end
                BT_TERM4: begin is_term = 1'b1; term_lane = 3'd4; end
                BT_TERM5: begin is_term = 1'b1; term_lane = 3'd5; end
                BT_TERM6: begin is_term = 1'b1; term_lane = 3'd6; end
                BT_TERM7: begin is_term = 1'b1; term_lane = 3'd7; end
                default:  illegal = 1'b1;
            endcase
            // Terminate: data below /T/, idles above; trailing codes are not checked
            if (is_term) begin
                for (int i = 0; i < 8; i++) begin
                    if (i < int'(term_lane))
                        data[8*i +: 8] = payload[8*i +: 8];
                    else if (i == int'(term_lane))
                        data[8*i +: 8] = XGMII_TERM;
                    else
                        data[8*i +: 8] = XGMII_IDLE;
                end
                ctl = 8'hFF << term_lane;
            end
        end else begin
            illegal = 1'b1;
        end
        if (illegal) begin
            is_start = 1'b0;
            is_term  = 1'b0;
            is_data  = 1'b0;
        end
    end

endmodule

// File: rtl/rx_pcs_decoder.sv
// 64b/66b receive decoder top: sequence FSM (RX_C/RX_D), two-column output
// buffer that splits each decoded block into lanes 0-3 then lanes 4-7,
// local-fault insertion while block lock is lost, and a saturating
// decode-error counter.
module rx_pcs_decoder
    import rx_pcs_decoder_pkg::*;
#(
    parameter int XGMII_DATA_WIDTH = 32,
    parameter int ERR_COUNT_WIDTH  = 16
) (
    input  logic                          rx_clk,
    input  logic                          rx_rst,
    input  logic [1:0]                    in_pcs_header,
    input  logic [63:0]                   in_pcs_block,
    input  logic                          in_pcs_valid,
    output logic                          out_pcs_ready,
    input  logic                          in_block_lock,
    output logic [XGMII_DATA_WIDTH-1:0]   out_xgmii_data,
    output logic [XGMII_DATA_WIDTH/8-1:0] out_xgmii_ctl,
    output logic                          out_xgmii_valid,
    input  logic                          in_xgmii_ready,
    output logic                          out_decode_error,
    output logic [ERR_COUNT_WIDTH-1:0]    out_decode_err_count
);

    logic [63:0] dec_word;
    logic [7:0]  dec_ctl;
    logic        dec_illegal;
    logic        dec_start;
    logic        dec_term;
    logic        dec_is_data;

    seq_state_t  state_q, state_d;
    buf_phase_t  phase_q, phase_d;
    logic [63:0] buf_data;
    logic [7:0]  buf_ctl;

    logic        load;
    logic        blk_take;
    logic        blk_bad;
    logic [63:0] load_data;
    logic [7:0]  load_ctl;

    pcs_block_decode u_decode (
        .header   (in_pcs_header),
        .block    (in_pcs_block),
        .data     (dec_word),
        .ctl      (dec_ctl),
        .illegal  (dec_illegal),
        .is_start (dec_start),
        .is_term  (dec_term),
        .is_data  (dec_is_data)
    );

    // A new block fits when the buffer is empty or its upper column leaves this cycle.
    // While unlocked the buffer refills with local fault whether or not a block is offered.
    assign out_pcs_ready = !rx_rst && (phase_q == BUF_EMPTY ||
                                       (phase_q == BUF_UPPER && in_xgmii_ready));
    assign load     = out_pcs_ready && (in_pcs_valid || !in_block_lock);
    assign blk_take = out_pcs_ready && in_pcs_valid && in_block_lock;

    // Sequence rules: decide next state and whether the taken block becomes /E/
    always_comb begin
        state_d = state_q;
        blk_bad = 1'b0;
        if (!in_block_lock) begin
            state_d = RX_C;
        end else if (blk_take) begin
            if (dec_illegal) begin
                blk_bad = 1'b1;
                state_d = RX_C;
            end else begin
                case (state_q)
                    RX_C: begin
                        if (dec_start)
                            state_d = RX_D;
                        else if (dec_is_data || dec_term)
                            blk_bad = 1'b1;
                    end
                    RX_D: begin
                        if (dec_term) begin
                            state_d = RX_C;
                        end else if (!dec_is_data) begin
                            blk_bad = 1'b1;
                            state_d = RX_C;
                        end
                    end
                    default: state_d = RX_C;
                endcase
            end
        end
    end

    // Select the 64-bit word entering the buffer
    always_comb begin
        load_data = dec_word;
        load_ctl  = dec_ctl;
        if (!in_block_lock) begin
            load_data = {LF_COLUMN, LF_COLUMN};
            load_ctl  = {LF_CTL, LF_CTL};
        end else if (blk_bad) begin
            load_data = {8{XGMII_ERROR}};
            load_ctl  = 8'hFF;
        end
    end

    // Buffer phase: lower column first, upper after it is taken
    always_comb begin
        phase_d = phase_q;
        case (phase_q)
            BUF_EMPTY: if (load) phase_d = BUF_LOWER;
            BUF_LOWER: if (in_xgmii_ready) phase_d = BUF_UPPER;
            BUF_UPPER: if (in_xgmii_ready) phase_d = load ? BUF_LOWER : BUF_EMPTY;
            default:   phase_d = BUF_EMPTY;
        endcase
    end

    // State, phase and buffer registers
    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            state_q  <= RX_C;
            phase_q  <= BUF_EMPTY;
            buf_data <= {8{XGMII_IDLE}};
            buf_ctl  <= 8'hFF;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            if (load) begin
                buf_data <= load_data;
                buf_ctl  <= load_ctl;
            end
        end
    end

    // Error pulse and saturating error count
    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            out_decode_error     <= 1'b0;
            out_decode_err_count <= '0;
        end else begin
            out_decode_error <= blk_bad;
            if (blk_bad && out_decode_err_count != {ERR_COUNT_WIDTH{1'b1}})
                out_decode_err_count <= out_decode_err_count + 1'b1;
        end
    end

    assign out_xgmii_valid = (phase_q != BUF_EMPTY);
    assign out_xgmii_data  = (phase_q == BUF_UPPER) ? buf_data[63:32] : buf_data[31:0];
    assign out_xgmii_ctl   = (phase_q == BUF_UPPER) ? buf_ctl[7:4]    : buf_ctl[3:0];

endmodule
